// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station with CDB wakeup and registered result; optional ALU_RS_OLDEST_FIRST_EN age-based selection
module alu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid_in,
  input  logic [4:0]       disp_op_in,
  input  logic [31:0]      disp_vj_in,
  input  logic [31:0]      disp_vk_in,
  input  logic             disp_qj_busy_in,
  input  logic             disp_qk_busy_in,
  input  logic [TAG_W-1:0] disp_qj_in,
  input  logic [TAG_W-1:0] disp_qk_in,
  input  logic [TAG_W-1:0] disp_dest_in,
  output logic             full_out,
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_value_in,
  output logic [31:0]      alu_op1_out,
  output logic [31:0]      alu_op2_out,
  output logic [4:0]       alu_op_out,
  input  logic [31:0]      alu_result_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [TAG_W-1:0] res_tag_out,
  output logic [31:0]      res_value_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             busy    [DEPTH];
  logic [4:0]       op      [DEPTH];
  logic [31:0]      vj      [DEPTH];
  logic [31:0]      vk      [DEPTH];
  logic             qj_busy [DEPTH];
  logic             qk_busy [DEPTH];
  logic [TAG_W-1:0] qj      [DEPTH];
  logic [TAG_W-1:0] qk      [DEPTH];
  logic [TAG_W-1:0] dest    [DEPTH];
`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [IW-1:0]    age     [DEPTH];
`endif

  logic [CW-1:0] count;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          disp_acc;
  logic          issue;

  // Pick the entry to issue: lowest ready index, or oldest ready entry when ages are kept
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i] && !qj_busy[i] && !qk_busy[i]) begin
`ifdef ALU_RS_OLDEST_FIRST_EN
        if (!sel_found || age[i] > age[sel_idx]) begin
`else
        if (!sel_found) begin
`endif
          sel_found = 1'b1;
          sel_idx   = IW'(i);
        end
      end
    end
  end

  // Lowest free slot receives the next dispatch
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign full_out = (count == CW'(DEPTH));
  assign disp_acc = disp_valid_in && !full_out && free_found && rdy_in && !flush_in;
  // A full result register only drains when the arbiter grants, so issue waits for that
  assign issue    = sel_found && rdy_in && !flush_in && (!res_valid_out || res_ready_in);

  assign alu_op1_out = sel_found ? vj[sel_idx] : 32'd0;
  assign alu_op2_out = sel_found ? vk[sel_idx] : 32'd0;
  assign alu_op_out  = sel_found ? op[sel_idx] : 5'd0;

  // Station entries: dispatch with CDB bypass, CDB wakeup, free on issue, flush clears all
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i]    <= 1'b0;
        op[i]      <= '0;
        vj[i]      <= '0;
        vk[i]      <= '0;
        qj_busy[i] <= 1'b0;
        qk_busy[i] <= 1'b0;
        qj[i]      <= '0;
        qk[i]      <= '0;
        dest[i]    <= '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
        age[i]     <= '0;
`endif
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          busy[i] <= 1'b0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_valid_in && busy[i] && qj_busy[i] && qj[i] == cdb_tag_in) begin
            vj[i]      <= cdb_value_in;
            qj_busy[i] <= 1'b0;
          end
          if (cdb_valid_in && busy[i] && qk_busy[i] && qk[i] == cdb_tag_in) begin
            vk[i]      <= cdb_value_in;
            qk_busy[i] <= 1'b0;
          end
`ifdef ALU_RS_OLDEST_FIRST_EN
          if (disp_acc && busy[i] && age[i] != IW'(DEPTH - 1)) begin
            age[i] <= age[i] + 1'b1;
          end
`endif
        end
        if (issue) begin
          busy[sel_idx] <= 1'b0;
        end
        if (disp_acc) begin
          busy[free_idx]    <= 1'b1;
          op[free_idx]      <= disp_op_in;
          dest[free_idx]    <= disp_dest_in;
          qj[free_idx]      <= disp_qj_in;
          qk[free_idx]      <= disp_qk_in;
          if (disp_qj_busy_in && cdb_valid_in && disp_qj_in == cdb_tag_in) begin
            vj[free_idx]      <= cdb_value_in;
            qj_busy[free_idx] <= 1'b0;
          end else begin
            vj[free_idx]      <= disp_vj_in;
            qj_busy[free_idx] <= disp_qj_busy_in;
          end
          if (disp_qk_busy_in && cdb_valid_in && disp_qk_in == cdb_tag_in) begin
            vk[free_idx]      <= cdb_value_in;
            qk_busy[free_idx] <= 1'b0;
          end else begin
            vk[free_idx]      <= disp_vk_in;
            qk_busy[free_idx] <= disp_qk_busy_in;
          end
`ifdef ALU_RS_OLDEST_FIRST_EN
          age[free_idx]     <= '0;
`endif
        end
        count <= count + CW'(disp_acc) - CW'(issue);
      end
    end
  end

  // Result register: load on issue, drain on grant, dropped by flush
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      res_valid_out <= 1'b0;
      res_tag_out   <= '0;
      res_value_out <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        res_valid_out <= 1'b0;
      end else if (issue) begin
        res_valid_out <= 1'b1;
        res_tag_out   <= dest[sel_idx];
        res_value_out <= alu_result_in;
      end else if (res_ready_in) begin
        res_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - self-checking bench for alu_rs
module tb_alu_rs;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SLL = 5'd5;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        disp_valid_in;
  logic [4:0]  disp_op_in;
  logic [31:0] disp_vj_in, disp_vk_in;
  logic        disp_qj_busy_in, disp_qk_busy_in;
  logic [3:0]  disp_qj_in, disp_qk_in, disp_dest_in;
  logic        full_out;
  logic        cdb_valid_in;
  logic [3:0]  cdb_tag_in;
  logic [31:0] cdb_value_in;
  logic [31:0] alu_op1_out, alu_op2_out;
  logic [4:0]  alu_op_out;
  logic [31:0] alu_result_in;
  logic        res_valid_out;
  logic        res_ready_in;
  logic [3:0]  res_tag_out;
  logic [31:0] res_value_out;

  int total = 0;
  int bad = 0;

  alu_rs #(.DEPTH(4), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid_in(disp_valid_in), .disp_op_in(disp_op_in),
    .disp_vj_in(disp_vj_in), .disp_vk_in(disp_vk_in),
    .disp_qj_busy_in(disp_qj_busy_in), .disp_qk_busy_in(disp_qk_busy_in),
    .disp_qj_in(disp_qj_in), .disp_qk_in(disp_qk_in), .disp_dest_in(disp_dest_in),
    .full_out(full_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .alu_op1_out(alu_op1_out), .alu_op2_out(alu_op2_out), .alu_op_out(alu_op_out),
    .alu_result_in(alu_result_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_tag_out(res_tag_out), .res_value_out(res_value_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference ALU returning the result combinationally
  always_comb begin
    case (alu_op_out)
      OP_ADD:  alu_result_in = alu_op1_out + alu_op2_out;
      OP_SUB:  alu_result_in = alu_op1_out - alu_op2_out;
      OP_AND:  alu_result_in = alu_op1_out & alu_op2_out;
      OP_OR:   alu_result_in = alu_op1_out | alu_op2_out;
      OP_XOR:  alu_result_in = alu_op1_out ^ alu_op2_out;
      OP_SLL:  alu_result_in = alu_op1_out << alu_op2_out[4:0];
      default: alu_result_in = 32'd0;
    endcase
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  dest;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic ab, input logic [3:0] at, input logic bb, input logic [3:0] bt,
                      input logic [3:0] d);
    disp_valid_in   = 1'b1;
    disp_op_in      = o;
    disp_vj_in      = a;
    disp_vk_in      = b;
    disp_qj_busy_in = ab;
    disp_qj_in      = at;
    disp_qk_busy_in = bb;
    disp_qk_in      = bt;
    disp_dest_in    = d;
  endtask

  task automatic nodisp();
    disp_valid_in   = 1'b0;
    disp_qj_busy_in = 1'b0;
    disp_qk_busy_in = 1'b0;
  endtask

  task automatic cdb(input logic v, input logic [3:0] t, input logic [31:0] val);
    cdb_valid_in = v;
    cdb_tag_in   = t;
    cdb_value_in = val;
  endtask

  task automatic chk_res(input string name, input logic [3:0] t, input logic [31:0] val);
    chk({name, ".valid"}, {31'd0, res_valid_out}, 32'd1);
    chk({name, ".tag"}, {28'd0, res_tag_out}, {28'd0, t});
    chk({name, ".value"}, res_value_out, val);
  endtask

  initial begin
    vecs[0] = '{OP_ADD, 32'd5,         32'd7,         4'd3, 32'd12};
    vecs[1] = '{OP_SUB, 32'd10,        32'd1,         4'd4, 32'd9};
    vecs[2] = '{OP_AND, 32'hffff0000,  32'h0ff00ff0,  4'd5, 32'h0ff00000};
    vecs[3] = '{OP_OR,  32'h0000f0f0,  32'h00000f0f,  4'd6, 32'h0000ffff};
    vecs[4] = '{OP_XOR, 32'haaaaaaaa,  32'hffffffff,  4'd7, 32'h55555555};
    vecs[5] = '{OP_SLL, 32'd1,         32'd31,        4'd8, 32'h80000000};
    vecs[6] = '{OP_SUB, 32'd0,         32'd1,         4'd9, 32'hffffffff};
    vecs[7] = '{OP_ADD, 32'hffffffff,  32'd1,         4'd15, 32'h00000000};

    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; res_ready_in = 1'b1;
    disp_op_in = '0; disp_vj_in = '0; disp_vk_in = '0; disp_qj_in = '0; disp_qk_in = '0;
    disp_dest_in = '0;
    nodisp();
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    tick();
    chk("rst.full", {31'd0, full_out}, 32'd0);
    chk("rst.valid", {31'd0, res_valid_out}, 32'd0);
    chk("rst.tag", {28'd0, res_tag_out}, 32'd0);
    chk("rst.value", res_value_out, 32'd0);
    chk("rst.op1", alu_op1_out, 32'd0);
    chk("rst.op", {27'd0, alu_op_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    // Single ready dispatches: two-cycle latency, result drops after one granted cycle
    for (int i = 0; i < 8; i++) begin
      disp(vecs[i].op, vecs[i].vj, vecs[i].vk, 1'b0, 4'd0, 1'b0, 4'd0, vecs[i].dest);
      tick();
      nodisp();
      chk($sformatf("vec%0d.early", i), {31'd0, res_valid_out}, 32'd0);
      tick();
      chk_res($sformatf("vec%0d", i), vecs[i].dest, vecs[i].exp);
      tick();
      chk($sformatf("vec%0d.drop", i), {31'd0, res_valid_out}, 32'd0);
    end
    chk("idle.op1", alu_op1_out, 32'd0);

    // Pending operand woken by a later broadcast
    disp(OP_SUB, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd5);
    tick();
    nodisp();
    tick();
    chk("wake.wait", {31'd0, res_valid_out}, 32'd0);
    cdb(1'b1, 4'd6, 32'd10);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    chk("wake.early", {31'd0, res_valid_out}, 32'd0);
    tick();
    chk_res("wake", 4'd5, 32'd9);
    tick();

    // Broadcast in the dispatch cycle is captured through the bypass
    disp(OP_SUB, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd6);
    cdb(1'b1, 4'd6, 32'd10);
    tick();
    nodisp();
    cdb(1'b0, 4'd0, 32'd0);
    chk("byp.early", {31'd0, res_valid_out}, 32'd0);
    tick();
    chk_res("byp", 4'd6, 32'd9);
    tick();

    // Fill the station with pending entries
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill%0d.full", i), {31'd0, full_out}, 32'd0);
      disp(OP_ADD, 32'd0, 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(8 + i));
      tick();
    end
    nodisp();
    chk("fill.full", {31'd0, full_out}, 32'd1);
    disp(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick();
    nodisp();
    tick();
    tick();
    chk("drop5.valid", {31'd0, res_valid_out}, 32'd0);
    cdb(1'b1, 4'd8, 32'd50);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    chk("wake8.full", {31'd0, full_out}, 32'd1);
    tick();
    chk_res("wake8", 4'd8, 32'd50);
    chk("wake8.fullfell", {31'd0, full_out}, 32'd0);
    tick();
    disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd12);
    tick();
    nodisp();
    chk("refill.full", {31'd0, full_out}, 32'd1);

    // Stalled result with three busy entries, then flush with a dispatch presented
    res_ready_in = 1'b0;
    cdb(1'b1, 4'd9, 32'd20);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk_res("stall9", 4'd9, 32'd21);
    tick();
    chk_res("stall9.hold", 4'd9, 32'd21);
    flush_in = 1'b1;
    disp(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
    tick();
    flush_in = 1'b0;
    nodisp();
    res_ready_in = 1'b1;
    chk("flush.valid", {31'd0, res_valid_out}, 32'd0);
    chk("flush.full", {31'd0, full_out}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) cdb(1'b1, 4'(10 + i), 32'd7);
      else cdb(1'b0, 4'd0, 32'd0);
      tick();
      chk($sformatf("postflush%0d.valid", i), {31'd0, res_valid_out}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd1);
      tick();
    end
    nodisp();
    chk("count3.full", {31'd0, full_out}, 32'd0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;

    // Two ready entries under a stalled arbiter, then back-to-back drain
    res_ready_in = 1'b0;
    disp(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    tick();
    disp(OP_ADD, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    tick();
    nodisp();
    chk_res("hold.first", 4'd1, 32'd3);
    tick();
    tick();
    chk_res("hold.still", 4'd1, 32'd3);
    rdy_in = 1'b0;
    res_ready_in = 1'b1;
    tick();
    chk_res("rdylow.hold", 4'd1, 32'd3);
    rdy_in = 1'b1;
    tick();
    chk_res("b2b.second", 4'd2, 32'd7);
    tick();
    chk("b2b.drop", {31'd0, res_valid_out}, 32'd0);

    // Age ordering: A in index 1 is older than B re-filling index 0
    disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd7);
    tick();
    disp(OP_ADD, 32'd0, 32'd100, 1'b1, 4'd5, 1'b0, 4'd0, 4'd10);
    tick();
    nodisp();
    cdb(1'b1, 4'd1, 32'd0);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk_res("age.x", 4'd7, 32'd0);
    disp(OP_ADD, 32'd0, 32'd200, 1'b1, 4'd5, 1'b0, 4'd0, 4'd11);
    tick();
    nodisp();
    cdb(1'b1, 4'd5, 32'd1);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    tick();
`ifdef ALU_RS_OLDEST_FIRST_EN
    chk_res("age.first", 4'd10, 32'd101);
    tick();
    chk_res("age.second", 4'd11, 32'd201);
`else
    chk_res("age.first", 4'd11, 32'd201);
    tick();
    chk_res("age.second", 4'd10, 32'd101);
`endif
    tick();

    // Asynchronous reset discards a pending result at once
    res_ready_in = 1'b0;
    disp(OP_ADD, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    tick();
    nodisp();
    tick();
    chk_res("prerst", 4'd4, 32'd4);
    #2;
    rst_in = 1'b0;
    #1;
    chk("asyncrst.valid", {31'd0, res_valid_out}, 32'd0);
    chk("asyncrst.tag", {28'd0, res_tag_out}, 32'd0);
    chk("asyncrst.value", res_value_out, 32'd0);
    chk("asyncrst.full", {31'd0, full_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    res_ready_in = 1'b1;
    tick();
    tick();
    chk("postrst.valid", {31'd0, res_valid_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station and issue scheduler for the shared integer ALU in the out-of-order core.
- Accepts decoded ALU/branch ops from dispatch and holds up to DEPTH entries.
- Captures missing operands by snooping the common data bus (CDB).
- Issues one ready entry per cycle to the combinational ALU.
- Registers the ALU result and presents it to the CDB arbiter under a valid/ready handshake.

## Interface
- DEPTH, 4, number of station entries (power of two, 2..16)
- TAG_W, 4, ROB tag width
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- rdy_in  input  1  global enable; when low all state holds
- flush_in  input  1  mispredict flush; clears station and output register
- disp_valid_in  input  1  dispatch request
- disp_op_in  input  5  ALU operation code (same encoding the ALU decodes)
- disp_vj_in / disp_vk_in  input  32  operand values
- disp_qj_busy_in / disp_qk_busy_in  input  1  operand still pending
- disp_qj_in / disp_qk_in  input  TAG_W  producer tag of pending operand
- disp_dest_in  input  TAG_W  destination ROB tag
- full_out  output  1  station full; dispatch ignored
- cdb_valid_in  input  1  CDB broadcast valid
- cdb_tag_in  input  TAG_W  CDB tag
- cdb_value_in  input  32  CDB value
- alu_op1_out / alu_op2_out  output  32  ALU operands
- alu_op_out  output  5  ALU operation
- alu_result_in  input  32  ALU result (combinational return)
- res_valid_out  output  1  result register holds a result
- res_ready_in  input  1  CDB arbiter grant
- res_tag_out  output  TAG_W  destination tag of result
- res_value_out  output  32  result value

## Operation
- Entry fields: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, dest. An entry is ready when busy && !qj_busy && !qk_busy.
- Dispatch: accepted when disp_valid_in && !full_out && rdy_in && !flush_in. Writes the lowest-index free entry.
- Dispatch bypass:
  - If a pending operand's tag equals cdb_tag_in while cdb_valid_in is high in the same cycle, the entry stores cdb_value_in and clears that busy bit.
  - Both operands are checked independently.
- Wakeup: on every enabled edge with cdb_valid_in high, each busy entry whose qj/qk matches cdb_tag_in captures cdb_value_in and clears the matching busy bit.
- Selection: issue the lowest-index ready entry (see Configuration). alu_op1/op2/op_out are driven from the selected entry. When no entry is selected they are driven to 0.
- Output register, two states:
  - EMPTY to FULL: an issue occurs; the edge loads alu_result_in and the entry's dest into the register and frees the entry.
  - FULL to EMPTY: on res_ready_in with no new issue.
  - FULL stays FULL on res_ready_in with an issue in the same cycle (back-to-back).
  - FULL without res_ready_in: holds, and issue is blocked.
- Issue is permitted only when the register is EMPTY or res_ready_in is high.
- full_out equals the registered count == DEPTH. A dispatch and an issue in the same cycle leave the count unchanged. A dispatch arriving while full_out is high is dropped even if an issue frees an entry that cycle.
- Flush: synchronous, overrides dispatch, issue and wakeup. All busy bits clear and res_valid_out drops to 0 at the next edge.
- rdy_in low: no register changes. Combinational outputs still reflect the held state.

## Timing
- Reset (asynchronous, rst_in low): all entries free, count 0, output register EMPTY.
- Reset values of outputs: full_out=0, res_valid_out=0, res_tag_out=0, res_value_out=0, alu_*_out=0. Release is synchronous to clk_in.
- Dispatch with both operands ready at edge N: entry is ready in cycle N+1; res_valid_out rises at edge N+2. Minimum latency is 2 cycles.
- An operand woken by the CDB at edge N makes the entry eligible in cycle N+1.
- Throughput: one result per cycle while res_ready_in stays high.
- res_valid_out, res_tag_out and res_value_out remain stable while res_valid_out && !res_ready_in.
- Reset asserted mid-operation discards all entries and any pending result immediately.

## Configuration
- ALU_RS_OLDEST_FIRST_EN:
  - Defined: each entry carries an age counter. Age is 0 at dispatch and increments on every enabled edge a dispatch occurs, saturating at DEPTH-1. Selection picks the ready entry with the greatest age, with ties broken toward the lower index.
  - Undefined: no age state is kept; selection is the lowest-index ready entry.

## Test plan
- Dispatch ADD vj=5, vk=7, both ready, dest=3, res_ready_in=1 -> cycle 2 after dispatch: res_valid_out=1, res_tag_out=3, res_value_out=12.
- Dispatch SUB with qj_busy tag=6, vk=1. CDB broadcasts tag 6, value 10, two cycles later -> result 9 appears 2 cycles after the broadcast edge. Same test with the broadcast in the dispatch cycle -> result 2 cycles after dispatch (bypass).
- Fill all 4 entries with pending operands -> full_out=1; a 5th dispatch is dropped; wake one entry -> full_out falls the cycle after that entry's issue.
- Hold res_ready_in=0 with 2 ready entries -> res_valid_out held with the first result, no second issue. Raise res_ready_in -> second result on the next edge, back-to-back.
- Assert flush_in with 3 busy entries and res_valid_out=1 -> next cycle count=0, full_out=0, res_valid_out=0. A dispatch presented in the flush cycle is dropped.
- With ALU_RS_OLDEST_FIRST_EN: dispatch entry A to index 1, free index 0, dispatch B to index 0, wake both together -> A issues first. Without the macro -> B issues first.
